// File: rtl/softmax_pkg.sv
// Shared constants for the softmax normaliser: FSM state encodings and default geometry.
package softmax_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  localparam int SOFTMAX_NUM_INPUTS = 4;
  localparam int SOFTMAX_DATA_WIDTH = 16;
  localparam int SOFTMAX_FRAC_BITS  = 8;

endpackage

// File: rtl/softmax_serial_div.sv
// Serial restoring divider: {x, FRAC zeros} / d, one quotient bit per cycle, saturated to DATA_WIDTH.
// Define SOFTMAX_NORM_ROUND_EN for round-to-nearest instead of truncation.
module softmax_serial_div #(
  parameter int N          = 24,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] d,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quot
);

  localparam int FRAC  = N - DATA_WIDTH;
  localparam int CNT_W = $clog2(N + 1);

  logic [N-1:0]          num_q;
  logic [N-1:0]          quo_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] div_q;
  logic [DATA_WIDTH-1:0] quot_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q;
  logic                  done_q;

  logic [DATA_WIDTH:0]   rem_sh;
  logic [DATA_WIDTH:0]   rem_sub;
  logic                  qbit;
  logic [DATA_WIDTH-1:0] rem_d;
  logic [N-1:0]          quo_d;
  logic [N:0]            quo_r;
  logic [DATA_WIDTH-1:0] quot_d;

  always_comb begin
    rem_sh  = {rem_q, num_q[N-1]};
    rem_sub = rem_sh - {1'b0, div_q};
    qbit    = (rem_sh >= {1'b0, div_q});
    rem_d   = qbit ? rem_sub[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
    quo_d   = {quo_q[N-2:0], qbit};
    quo_r   = {1'b0, quo_d};
`ifdef SOFTMAX_NORM_ROUND_EN
    // Round half up using the final remainder: 2*rem >= d.
    if ({rem_d, 1'b0} >= {1'b0, div_q}) begin
      quo_r = quo_r + {{N{1'b0}}, 1'b1};
    end
`endif
    quot_d = (|quo_r[N:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}} : quo_r[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (start) begin
      num_q <= {x, {FRAC{1'b0}}};
      quo_q <= '0;
      rem_q <= '0;
      div_q <= d;
    end else if (busy_q) begin
      num_q <= num_q << 1;
      quo_q <= quo_d;
      rem_q <= rem_d;
      if (cnt_q == CNT_W'(1)) begin
        quot_q <= quot_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        busy_q <= 1'b1;
        cnt_q  <= CNT_W'(N);
      end else if (busy_q) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;

endmodule

// File: rtl/softmax_normalizer.sv
// Softmax final stage: divides each latched exp element by the sum and streams Q(FRAC_BITS) results.
// Optional SOFTMAX_NORM_ROUND_EN selects round-to-nearest inside the divider.
module softmax_normalizer
  import softmax_pkg::*;
#(
  parameter int NUM_INPUTS = SOFTMAX_NUM_INPUTS,
  parameter int DATA_WIDTH = SOFTMAX_DATA_WIDTH,
  parameter int FRAC_BITS  = SOFTMAX_FRAC_BITS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_vec,
  input  logic [DATA_WIDTH-1:0]            in_sum,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [$clog2(NUM_INPUTS)-1:0]    out_idx,
  output logic                             out_last,
  output logic                             div_zero
);

  localparam int N     = DATA_WIDTH + FRAC_BITS;
  localparam int IDX_W = $clog2(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] vec_q [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] sum_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  div_zero_q;

  logic                  accept;
  logic                  hs;
  logic                  is_last;
  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  logic [DATA_WIDTH-1:0] div_x;
  logic [DATA_WIDTH-1:0] div_d;
  logic [DATA_WIDTH-1:0] div_quot;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid_q && out_ready;
  assign is_last  = (idx_q == LAST_IDX);

  // Element 0 is fed straight from the input on accept; later elements come from the latch.
  assign div_x     = accept ? in_vec[DATA_WIDTH-1:0] : vec_q[idx_q + IDX_W'(1)];
  assign div_d     = accept ? in_sum : sum_q;
  assign div_start = !div_busy &&
                     ((accept && (in_sum != '0)) || (hs && !is_last && !div_zero_q));

  softmax_serial_div #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .x     (div_x),
    .d     (div_d),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        vec_q[i] <= in_vec[i*DATA_WIDTH +: DATA_WIDTH];
      end
      sum_q <= in_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            idx_q      <= '0;
            out_last_q <= 1'b0;
            if (in_sum == '0) begin
              div_zero_q  <= 1'b1;
              out_data_q  <= '0;
              out_valid_q <= 1'b1;
              state_q     <= S_OUT;
            end else begin
              div_zero_q <= 1'b0;
              state_q    <= S_DIV;
            end
          end
        end
        S_DIV: begin
          if (div_done) begin
            out_data_q  <= div_quot;
            out_valid_q <= 1'b1;
            out_last_q  <= is_last;
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          if (hs) begin
            if (is_last) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              if (div_zero_q) begin
                out_last_q <= ((idx_q + IDX_W'(1)) == LAST_IDX);
              end else begin
                out_valid_q <= 1'b0;
                state_q     <= S_DIV;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign out_last  = out_last_q;
  assign div_zero  = div_zero_q;

endmodule
